reg_fifo8: RTL and testbench

REG_FIFO8 -- requirements
Module: reg_fifo8

---
 rtl/fifo_pkg.sv | 7 +
 rtl/dff.sv | 10 +
 rtl/register16.sv | 15 +
 rtl/reg_fifo8.sv | 83 ++++++++
 tb/tb_reg_fifo8.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and pointer type for the register-based FIFO
package fifo_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;
    localparam int PTR_W = $clog2(DEF_DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/dff.sv
// dff: plain WIDTH-bit D flip-flop without reset
module dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) q <= d;
endmodule

// File: rtl/register16.sv
// register16: load-enabled storage register built on dff
module register16
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_d;
    always_comb q_d = en ? d : q;
    dff #(.WIDTH(WIDTH)) u_dff (.clk(clk), .d(q_d), .q(q));
endmodule

// File: rtl/reg_fifo8.sv
// reg_fifo8: register-based FIFO with registered read data and sticky error flags
module reg_fifo8
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     clr_err,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d, underflow_q, underflow_d;
    logic             wr_ok, rd_ok;
    logic [WIDTH-1:0] mem [DEPTH];

    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign rd_ok = rd_en & ~empty;
    // a read in the same cycle frees the slot, so a full FIFO can still take a write
    assign wr_ok = wr_en & (~full | rd_ok);

    for (genvar g = 0; g < DEPTH; g++) begin : g_mem
        register16 #(.WIDTH(WIDTH)) u_reg (
            .clk(clk),
            .en (wr_ok && wr_ptr_q == AW'(g)),
            .d  (wr_data),
            .q  (mem[g])
        );
    end

    always_comb begin
        wr_ptr_d    = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q + CW'(wr_ok) - CW'(rd_ok);
        rd_data_d   = rd_ok ? mem[rd_ptr_q] : rd_data_q;
        rd_valid_d  = rd_ok;
        overflow_d  = (wr_en & ~wr_ok) | (overflow_q & ~clr_err);
        underflow_d = (rd_en & ~rd_ok) | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_reg_fifo8.sv
// tb_reg_fifo8: directed self-checking bench for reg_fifo8
module tb_reg_fifo8;
    logic        clk, rst_n, wr_en, rd_en, clr_err;
    logic [15:0] wr_data, rd_data;
    logic        rd_valid, full, empty, overflow, underflow;
    logic [3:0]  count;
    int          checks, errors;

    reg_fifo8 dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty), .count(count),
        .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic [15:0] wd, input logic r, input logic c);
        wr_en = w;
        wr_data = wd;
        rd_en = r;
        clr_err = c;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr_err = 1'b0;
        wr_data = '0;
        #3;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_udf", underflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // fill
        for (int i = 1; i <= 8; i++) begin
            step(1, 16'(i), 0, 0);
            check("fill_count", count, i);
        end
        check("fill_full", full, 1);
        check("fill_empty", empty, 0);
        // overflow
        step(1, 16'hDEAD, 0, 0);
        check("ovf_count", count, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_valid", rd_valid, 0);
        step(0, 0, 0, 1);
        check("ovf_clr", overflow, 0);
        // drain
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1, 0);
            check("drain_valid", rd_valid, 1);
            check("drain_data", rd_data, i);
            check("drain_count", count, 8 - i);
        end
        check("drain_empty", empty, 1);
        step(0, 0, 0, 0);
        check("idle_valid", rd_valid, 0);
        check("idle_hold", rd_data, 16'h0008);
        // simultaneous on empty
        step(1, 16'h00AA, 1, 0);
        check("se_udf", underflow, 1);
        check("se_valid", rd_valid, 0);
        check("se_count", count, 1);
        check("se_hold", rd_data, 16'h0008);
        step(0, 0, 1, 0);
        check("se_data", rd_data, 16'h00AA);
        check("se_valid2", rd_valid, 1);
        check("se_count2", count, 0);
        step(0, 0, 1, 1);
        check("clr_new_err_wins", underflow, 1);
        step(0, 0, 0, 1);
        check("udf_clr", underflow, 0);
        // simultaneous on full
        for (int i = 1; i <= 8; i++) step(1, 16'(i), 0, 0);
        check("sf_full", full, 1);
        step(1, 16'h0009, 1, 0);
        check("sf_data", rd_data, 16'h0001);
        check("sf_count", count, 8);
        check("sf_ovf", overflow, 0);
        for (int i = 2; i <= 9; i++) begin
            step(0, 0, 1, 0);
            check("sf_drain", rd_data, i);
        end
        check("sf_empty", empty, 1);
        // simultaneous mid-occupancy
        step(1, 16'h0A0A, 0, 0);
        step(1, 16'h0B0B, 0, 0);
        step(1, 16'h0C0C, 1, 0);
        check("mid_data", rd_data, 16'h0A0A);
        check("mid_count", count, 2);
        step(0, 0, 1, 0);
        check("mid_b", rd_data, 16'h0B0B);
        step(0, 0, 1, 0);
        check("mid_c", rd_data, 16'h0C0C);
        check("mid_empty", empty, 1);
        // wrap
        for (int i = 0; i < 12; i++) begin
            step(1, 16'h0100 + 16'(i), 0, 0);
            step(0, 0, 1, 0);
            check("wrap_data", rd_data, 32'h100 + i);
            check("wrap_count", count, 0);
        end
        // async reset mid-queue
        step(1, 16'h0011, 0, 0);
        step(1, 16'h0022, 0, 0);
        step(1, 16'h0033, 0, 0);
        step(0, 0, 1, 0);
        check("ar_pre_data", rd_data, 16'h0011);
        check("ar_pre_count", count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_count", count, 0);
        check("ar_empty", empty, 1);
        check("ar_valid", rd_valid, 0);
        check("ar_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 16'h0055, 0, 0);
        check("ar_wcount", count, 1);
        step(0, 0, 1, 0);
        check("ar_new", rd_data, 16'h0055);
        check("ar_new_empty", empty, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
